fetch_sequencer: RTL and testbench

Parametrised instruction fetch/sequence controller for the OSECPU core, successor to the fixed two-state-pair fetch controller. It fetches variable-length instructions (1..MAX_WORDS words) over a ready/ack memory handshake that tolerates wait states, presents each complete instruction to the execution unit with a valid/done handshake, and maintains the PC and the control register (CR). CR holds halt, skip and length-error state. It sits between instruction memory and the decode/execute stage.

---
 rtl/fetch_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Variable-length instruction fetch controller: memory handshake, PC, CR and exec handshake.
// Defining FETCH_STEP_EN adds step_mode_i, which forces HALT after every executed instruction.
module fetch_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter int                MAX_WORDS = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    output logic                                mem_req_o,
    output logic [ADDR_W-1:0]                   mem_addr_o,
    input  logic                                mem_ack_i,
    input  logic [DATA_W-1:0]                   mem_rdata_i,
    output logic [7:0]                          dec_op_o,
    input  logic [$clog2(MAX_WORDS+1)-1:0]      dec_len_i,
    output logic [MAX_WORDS*DATA_W-1:0]         instr_o,
    output logic [$clog2(MAX_WORDS+1)-1:0]      instr_len_o,
    output logic [ADDR_W-1:0]                   exec_pc_o,
    output logic                                exec_valid_o,
    input  logic                                exec_done_i,
    input  logic                                pc_update_req_i,
    input  logic [ADDR_W-1:0]                   pc_update_addr_i,
    input  logic                                hlt_req_i,
    input  logic                                cnd_false_i,
    input  logic                                resume_i,
`ifdef FETCH_STEP_EN
    input  logic                                step_mode_i,
`endif
    output logic [ADDR_W-1:0]                   pc_o,
    output logic [1:0]                          state_o,
    output logic [7:0]                          cr_o
);

    // state    | meaning
    // ST_FETCH | requesting words at pc until the instruction is complete
    // ST_EXEC  | instruction presented on instr_o, waiting for exec_done_i
    // ST_HALT  | idle until resume_i
    localparam int               LEN_W    = $clog2(MAX_WORDS+1);
    localparam logic [1:0]       ST_FETCH = 2'd0;
    localparam logic [1:0]       ST_EXEC  = 2'd1;
    localparam logic [1:0]       ST_HALT  = 2'd2;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_WORDS);

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [ADDR_W-1:0] exec_pc_q, exec_pc_d;
    logic [LEN_W-1:0]  k_q,       k_d;
    logic [LEN_W-1:0]  len_q,     len_d;
    logic [DATA_W-1:0] slot_q [MAX_WORDS];
    logic [DATA_W-1:0] slot_d [MAX_WORDS];
    logic              halt_q,    halt_d;
    logic              skip_q,    skip_d;
    logic              len_err_q, len_err_d;

    logic [LEN_W-1:0]  word0_len;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  k_inc;
    logic              last_word;
    logic              step_stop;

`ifdef FETCH_STEP_EN
    assign step_stop = step_mode_i;
`else
    assign step_stop = 1'b0;
`endif

    // A zero length is a one-word instruction; oversize lengths are clamped and flagged.
    always_comb begin
        word0_len = dec_len_i;
        if (dec_len_i == '0) begin
            word0_len = LEN_ONE;
        end else if (dec_len_i > LEN_MAX) begin
            word0_len = LEN_MAX;
        end
    end

    assign k_inc     = k_q + LEN_ONE;
    assign cur_len   = (k_q == '0) ? word0_len : len_q;
    assign last_word = (k_inc == cur_len);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        exec_pc_d = exec_pc_q;
        k_d       = k_q;
        len_d     = len_q;
        halt_d    = halt_q;
        skip_d    = skip_q;
        len_err_d = len_err_q;
        for (int i = 0; i < MAX_WORDS; i++) begin
            slot_d[i] = slot_q[i];
        end

        case (state_q)
            ST_FETCH: begin
                if (mem_ack_i) begin
                    pc_d = pc_q + ADDR_W'(1);
                    k_d  = k_inc;
                    if (k_q == '0) begin
                        for (int i = 0; i < MAX_WORDS; i++) begin
                            slot_d[i] = '0;
                        end
                        len_d     = word0_len;
                        exec_pc_d = pc_q;
                        if (dec_len_i > LEN_MAX) begin
                            len_err_d = 1'b1;
                        end
                    end
                    for (int i = 0; i < MAX_WORDS; i++) begin
                        if (LEN_W'(i) == k_q) begin
                            slot_d[i] = mem_rdata_i;
                        end
                    end
                    if (last_word) begin
                        k_d = '0;
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (exec_done_i) begin
                    if (pc_update_req_i) begin
                        pc_d = pc_update_addr_i;
                    end
                    if (cnd_false_i) begin
                        skip_d = 1'b1;
                    end
                    k_d = '0;
                    if (hlt_req_i || step_stop) begin
                        halt_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    halt_d  = 1'b0;
                    k_d     = '0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            exec_pc_q <= '0;
            k_q       <= '0;
            len_q     <= '0;
            halt_q    <= 1'b0;
            skip_q    <= 1'b0;
            len_err_q <= 1'b0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            exec_pc_q <= exec_pc_d;
            k_q       <= k_d;
            len_q     <= len_d;
            halt_q    <= halt_d;
            skip_q    <= skip_d;
            len_err_q <= len_err_d;
            for (int i = 0; i < MAX_WORDS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Reset holds the state at FETCH, so the request is gated off until it deasserts.
    assign mem_req_o    = (state_q == ST_FETCH) && !reset_i;
    assign mem_addr_o   = pc_q;
    assign dec_op_o     = mem_rdata_i[DATA_W-1 -: 8];
    assign exec_valid_o = (state_q == ST_EXEC);
    assign instr_len_o  = len_q;
    assign exec_pc_o    = exec_pc_q;
    assign pc_o         = pc_q;
    assign state_o      = state_q;
    assign cr_o         = {5'b0, len_err_q, skip_q, halt_q};

    always_comb begin
        instr_o = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            instr_o[i*DATA_W +: DATA_W] = slot_q[i];
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory/decoder/exec responder plus per-scenario tasks.
// Expected instructions are queued per program and compared whenever exec_valid is seen.
module tb_fetch_sequencer;

    typedef struct {
        logic [15:0]  pc;
        logic [2:0]   len;
        logic [127:0] words;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [7:0]   dec_op;
    logic [2:0]   dec_len;
    logic [127:0] instr;
    logic [2:0]   instr_len;
    logic [15:0]  exec_pc;
    logic         exec_valid;
    logic         exec_done;
    logic         pc_update_req;
    logic [15:0]  pc_update_addr;
    logic         hlt_req;
    logic         cnd_false;
    logic         resume;
    logic [15:0]  pc;
    logic [1:0]   state;
    logic [7:0]   cr;
`ifdef FETCH_STEP_EN
    logic         step_mode;
`endif

    logic [31:0]  mem [0:65535];
    exp_t         sb [$];
    int           exec_log [$];
    logic [15:0]  ack_log [$];
    int           total;
    int           bad;
    int           cyc;
    int           wcnt;
    int           wait_n;
    int           last_ack_cyc;
    logic         spur_ack;

    fetch_sequencer #(.ADDR_W(16), .DATA_W(32), .MAX_WORDS(4), .RESET_PC(16'h0000)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_ack_i        (mem_ack),
        .mem_rdata_i      (mem_rdata),
        .dec_op_o         (dec_op),
        .dec_len_i        (dec_len),
        .instr_o          (instr),
        .instr_len_o      (instr_len),
        .exec_pc_o        (exec_pc),
        .exec_valid_o     (exec_valid),
        .exec_done_i      (exec_done),
        .pc_update_req_i  (pc_update_req),
        .pc_update_addr_i (pc_update_addr),
        .hlt_req_i        (hlt_req),
        .cnd_false_i      (cnd_false),
        .resume_i         (resume),
`ifdef FETCH_STEP_EN
        .step_mode_i      (step_mode),
`endif
        .pc_o             (pc),
        .state_o          (state),
        .cr_o             (cr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // External decoder: A0 jump, B0 jump+halt, C0 cond-false, F0 halt.
    function automatic logic [2:0] len_of(input logic [7:0] op);
        case (op)
            8'h00:   len_of = 3'd0;
            8'h02:   len_of = 3'd2;
            8'h03:   len_of = 3'd3;
            8'h07:   len_of = 3'd7;
            default: len_of = 3'd1;
        endcase
    endfunction

    // Memory and execution-unit responder, acting 1 time unit after each falling edge.
    initial begin
        exp_t e;
        logic [7:0] op;
        mem_ack = 0; mem_rdata = 0; dec_len = 0; exec_done = 0;
        pc_update_req = 0; pc_update_addr = 0; hlt_req = 0; cnd_false = 0;
        cyc = 0; wcnt = 0;
        forever begin
            @(negedge clk);
            #1;
            mem_ack = 0; exec_done = 0; pc_update_req = 0; hlt_req = 0; cnd_false = 0;
            if (reset) begin
                cyc = 0;
                wcnt = 0;
            end else begin
                if (mem_req || spur_ack) begin
                    if (spur_ack || wcnt == wait_n) begin
                        mem_ack   = 1;
                        mem_rdata = mem[mem_addr];
                        dec_len   = len_of(mem_rdata[31:24]);
                        wcnt      = 0;
                        if (mem_req) begin
                            ack_log.push_back(mem_addr);
                            last_ack_cyc = cyc;
                        end
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
                if (exec_valid) begin
                    exec_log.push_back(cyc);
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: exec_pc=%h instr_len=%0d, required no execution", exec_pc, instr_len);
                    end else begin
                        e = sb.pop_front();
                        if (exec_pc !== e.pc || instr_len !== e.len || instr !== e.words) begin
                            bad++;
                            $display("FAIL sb_instr: got pc=%h len=%0d instr=%h, required pc=%h len=%0d instr=%h",
                                     exec_pc, instr_len, instr, e.pc, e.len, e.words);
                        end
                    end
                    op = instr[31:24];
                    exec_done      = 1;
                    pc_update_addr = instr[15:0];
                    pc_update_req  = (op == 8'hA0) || (op == 8'hB0);
                    hlt_req        = (op == 8'hB0) || (op == 8'hF0);
                    cnd_false      = (op == 8'hC0);
                end
                cyc++;
            end
        end
    end

    task automatic start_prog(input int w);
        reset = 1; spur_ack = 0; resume = 0;
        @(negedge clk);
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        sb.delete(); exec_log.delete(); ack_log.delete();
        wait_n = w;
        last_ack_cyc = -100;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 0;
        #2;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [15:0] p, input logic [2:0] n);
        exp_t e;
        e.pc = p; e.len = n; e.words = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(n)) e.words[i*32 +: 32] = mem[p + 16'(i)];
        end
        sb.push_back(e);
    endtask

    task automatic wait_halt(input int limit);
        int n;
        n = 0;
        while (state !== 2'd2 && n < limit) begin
            @(negedge clk);
            #2;
            n++;
        end
    endtask

    task automatic test_reset();
        start_prog(3);
        mem[0] = 32'h03_000000;
        total++;
        if (mem_req !== 0 || exec_valid !== 0 || state !== 0 || cr !== 0 || pc !== 0 ||
            instr !== 0 || instr_len !== 0 || exec_pc !== 0) begin
            bad++;
            $display("FAIL reset_state: req=%b valid=%b state=%0d cr=%h pc=%h len=%0d epc=%h, required all 0",
                     mem_req, exec_valid, state, cr, pc, instr_len, exec_pc);
        end
        release_reset();
        total++;
        if (mem_req !== 1 || mem_addr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_first_req: req=%b addr=%h, required 1 0000", mem_req, mem_addr);
        end
        step(5);
        total++;
        if (pc !== 16'h0001 || instr[31:0] !== 32'h03_000000) begin
            bad++;
            $display("FAIL reset_midfetch_pre: pc=%h slot0=%h, required 0001 03000000", pc, instr[31:0]);
        end
        reset = 1;
        #1;
        total++;
        if (mem_req !== 0 || state !== 0 || pc !== 0 || instr !== 0 || instr_len !== 0 || exec_pc !== 0) begin
            bad++;
            $display("FAIL reset_async: req=%b state=%0d pc=%h instr=%h len=%0d, required all 0",
                     mem_req, state, pc, instr, instr_len);
        end
    endtask

    task automatic test_back_to_back();
        start_prog(0);
        mem[0] = 32'h01_000011;
        mem[1] = 32'h01_000022;
        mem[2] = 32'hF0_000000;
        push_exp(16'h0, 3'd1); push_exp(16'h1, 3'd1); push_exp(16'h2, 3'd1);
        release_reset();
        total++;
        if (dec_op !== 8'h01) begin
            bad++;
            $display("FAIL b2b_dec_op: got %h, required 01", dec_op);
        end
        step(12);
        total++;
        if (exec_log.size() != 3 || exec_log[0] != 1 || exec_log[1] != 3 || exec_log[2] != 5) begin
            bad++;
            $display("FAIL b2b_exec_cycles: n=%0d cycles %0d %0d %0d, required 3 cycles 1 3 5",
                     exec_log.size(), exec_log[0], exec_log[1], exec_log[2]);
        end
        total++;
        if (ack_log.size() != 3 || ack_log[0] !== 16'h0 || ack_log[1] !== 16'h1 || ack_log[2] !== 16'h2) begin
            bad++;
            $display("FAIL b2b_addrs: n=%0d addrs %h %h %h, required 3 addrs 0000 0001 0002",
                     ack_log.size(), ack_log[0], ack_log[1], ack_log[2]);
        end
        total++;
        if (state !== 2'd2 || cr !== 8'h01 || mem_req !== 0 || pc !== 16'h3 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_halt: state=%0d cr=%h req=%b pc=%h pending=%0d, required 2 01 0 0003 0",
                     state, cr, mem_req, pc, sb.size());
        end
    endtask

    task automatic test_wait_states();
        int n;
        start_prog(2);
        mem[16'h0000] = 32'hA0_000010;
        mem[16'h0010] = 32'h03_ABCDEF;
        mem[16'h0011] = 32'h1111_1111;
        mem[16'h0012] = 32'h2222_2222;
        mem[16'h0013] = 32'hF0_000000;
        push_exp(16'h0, 3'd1); push_exp(16'h10, 3'd3); push_exp(16'h13, 3'd1);
        release_reset();
        n = 0;
        while (!(exec_valid === 1 && exec_pc === 16'h0010) && n < 80) begin
            step(1);
            n++;
        end
        total++;
        if (pc !== 16'h0013 || instr_len !== 3'd3 ||
            instr !== {32'h0, 32'h2222_2222, 32'h1111_1111, 32'h03_ABCDEF}) begin
            bad++;
            $display("FAIL wait_instr: pc=%h len=%0d instr=%h, required 0013 3 00000000222222221111111103abcdef",
                     pc, instr_len, instr);
        end
        total++;
        if ((cyc - 1) - last_ack_cyc != 1) begin
            bad++;
            $display("FAIL wait_exec_latency: gap=%0d cycles, required 1", (cyc - 1) - last_ack_cyc);
        end
        wait_halt(80);
        total++;
        if (state !== 2'd2 || cr !== 8'h01 || sb.size() != 0 || ack_log.size() != 5) begin
            bad++;
            $display("FAIL wait_end: state=%0d cr=%h pending=%0d acks=%0d, required 2 01 0 5",
                     state, cr, sb.size(), ack_log.size());
        end
    endtask

    task automatic test_skip();
        start_prog(0);
        mem[0] = 32'hC0_000000;
        mem[1] = 32'h02_000001;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h01_000003;
        mem[4] = 32'hF0_000000;
        push_exp(16'h0, 3'd1); push_exp(16'h3, 3'd1); push_exp(16'h4, 3'd1);
        release_reset();
        step(2);
        total++;
        if (cr !== 8'h02) begin
            bad++;
            $display("FAIL skip_set: cr=%h, required 02", cr);
        end
        step(10);
        total++;
        if (exec_log.size() != 3 || exec_log[0] != 1 || exec_log[1] != 5 || exec_log[2] != 7) begin
            bad++;
            $display("FAIL skip_exec_cycles: n=%0d cycles %0d %0d %0d, required 3 cycles 1 5 7",
                     exec_log.size(), exec_log[0], exec_log[1], exec_log[2]);
        end
        total++;
        if (state !== 2'd2 || cr !== 8'h01 || sb.size() != 0) begin
            bad++;
            $display("FAIL skip_end: state=%0d cr=%h pending=%0d, required 2 01 0", state, cr, sb.size());
        end
    endtask

    task automatic test_branch_halt();
        start_prog(0);
        mem[16'h0000] = 32'hB0_000040;
        mem[16'h0040] = 32'h01_000040;
        mem[16'h0041] = 32'hF0_000000;
        push_exp(16'h0, 3'd1); push_exp(16'h40, 3'd1); push_exp(16'h41, 3'd1);
        release_reset();
        step(3);
        total++;
        if (state !== 2'd2 || cr !== 8'h01 || mem_req !== 0 || pc !== 16'h0040) begin
            bad++;
            $display("FAIL bh_halt: state=%0d cr=%h req=%b pc=%h, required 2 01 0 0040", state, cr, mem_req, pc);
        end
        spur_ack = 1;
        step(2);
        spur_ack = 0;
        total++;
        if (pc !== 16'h0040 || state !== 2'd2 || ack_log.size() != 1) begin
            bad++;
            $display("FAIL bh_stray_ack: pc=%h state=%0d acks=%0d, required 0040 2 1", pc, state, ack_log.size());
        end
        resume = 1;
        @(negedge clk);
        resume = 0;
        #2;
        total++;
        if (mem_req !== 1 || mem_addr !== 16'h0040 || cr[0] !== 1'b0) begin
            bad++;
            $display("FAIL bh_resume: req=%b addr=%h halt=%b, required 1 0040 0", mem_req, mem_addr, cr[0]);
        end
        step(1);
        wait_halt(40);
        total++;
        if (state !== 2'd2 || sb.size() != 0 || ack_log.size() != 3 || ack_log[1] !== 16'h0040) begin
            bad++;
            $display("FAIL bh_end: state=%0d pending=%0d acks=%0d addr1=%h, required 2 0 3 0040",
                     state, sb.size(), ack_log.size(), ack_log[1]);
        end
    endtask

    task automatic test_len_clamp_wrap();
        int n;
        start_prog(0);
        mem[16'h0000] = 32'hA0_00FFFF;
        mem[16'hFFFF] = 32'h07_000001;
        mem[16'h0001] = 32'h5555_5555;
        mem[16'h0002] = 32'h6666_6666;
        mem[16'h0003] = 32'h00_000003;
        mem[16'h0004] = 32'hF0_000000;
        push_exp(16'h0, 3'd1); push_exp(16'hFFFF, 3'd4); push_exp(16'h3, 3'd1); push_exp(16'h4, 3'd1);
        release_reset();
        n = 0;
        while (!(exec_valid === 1 && exec_pc === 16'hFFFF) && n < 40) begin
            step(1);
            n++;
        end
        total++;
        if (instr_len !== 3'd4 || cr !== 8'h04 || pc !== 16'h0003 ||
            instr !== {32'h6666_6666, 32'h5555_5555, 32'hA0_00FFFF, 32'h07_000001}) begin
            bad++;
            $display("FAIL clamp_instr: len=%0d cr=%h pc=%h instr=%h, required 4 04 0003 6666666655555555a000ffff07000001",
                     instr_len, cr, pc, instr);
        end
        wait_halt(40);
        total++;
        if (cr !== 8'h05 || sb.size() != 0) begin
            bad++;
            $display("FAIL clamp_sticky: cr=%h pending=%0d, required 05 0", cr, sb.size());
        end
        total++;
        if (ack_log.size() != 7 || ack_log[1] !== 16'hFFFF || ack_log[2] !== 16'h0000 ||
            ack_log[4] !== 16'h0002 || ack_log[5] !== 16'h0003) begin
            bad++;
            $display("FAIL wrap_addrs: n=%0d addrs %h %h %h %h, required 7 ffff 0000 0002 0003",
                     ack_log.size(), ack_log[1], ack_log[2], ack_log[4], ack_log[5]);
        end
    endtask

`ifdef FETCH_STEP_EN
    task automatic test_step();
        start_prog(0);
        step_mode = 1;
        for (int a = 0; a < 8; a++) mem[a] = 32'h01_000000 | 32'(a);
        for (int a = 0; a < 4; a++) push_exp(16'(a), 3'd1);
        release_reset();
        wait_halt(20);
        for (int r = 0; r < 3; r++) begin
            resume = 1;
            @(negedge clk);
            resume = 0;
            wait_halt(20);
        end
        step(3);
        total++;
        if (exec_log.size() != 4 || state !== 2'd2 || cr !== 8'h01 || sb.size() != 0) begin
            bad++;
            $display("FAIL step_count: execs=%0d state=%0d cr=%h pending=%0d, required 4 2 01 0",
                     exec_log.size(), state, cr, sb.size());
        end
        step_mode = 0;
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        reset = 0; resume = 0; spur_ack = 0; wait_n = 0; last_ack_cyc = -100;
`ifdef FETCH_STEP_EN
        step_mode = 0;
`endif
        #3;
        reset = 1;
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_skip();
        test_branch_halt();
        test_len_clamp_wrap();
`ifdef FETCH_STEP_EN
        test_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
